// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StChk,
        StDone,
        StError
    } state_e;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADDR_SHIFT     = 2;

    typedef struct packed {
        logic byte_ready;
        logic busy;
        logic done;
        logic error;
        logic cpu_reset_hold;
    } status_t;

    // Status outputs are a pure function of the state being entered.
    function automatic status_t decode_status(state_e s);
        status_t st;
        st.byte_ready     = (s == StLen) || (s == StData) || (s == StChk);
        st.busy           = (s == StLen) || (s == StData) || (s == StWrite) || (s == StChk);
        st.done           = (s == StDone);
        st.error          = (s == StError);
        st.cpu_reset_hold = (s != StDone);
        return st;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write bus of the loader.
// master: loader side; slave: stream source / memory side.
interface program_loader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [7:0]            ByteIn;
    logic                  ByteValid;
    logic                  ByteReady;
    logic                  WriteEnable;
    logic [DATA_WIDTH-1:0] WriteAddress;
    logic [DATA_WIDTH-1:0] WriteData;

    modport master (
        input  ByteIn,
        input  ByteValid,
        output ByteReady,
        output WriteEnable,
        output WriteAddress,
        output WriteData
    );

    modport slave (
        output ByteIn,
        output ByteValid,
        input  ByteReady,
        input  WriteEnable,
        input  WriteAddress,
        input  WriteData
    );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Little-endian byte assembler: each loaded byte enters at the top and
// shifts down, so after four loads the first byte sits in bits 7:0.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          clear_i,
    input  logic                          load_i,
    input  logic [7:0]                    byte_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_next_o,
    output logic [1:0]                    count_o
);

    logic [8*BYTES_PER_WORD-1:0] word_q;
    logic [1:0]                  count_q;

    // Word value including the byte offered this cycle.
    always_comb begin
        word_next_o = {byte_i, word_q[8*BYTES_PER_WORD-1:8]};
    end

    // Shift register and byte counter; clear takes priority over load.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            word_q  <= '0;
            count_q <= '0;
        end else if (load_i) begin
            word_q  <= word_next_o;
            count_q <= count_q + 2'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/program_loader.sv
// Serial program loader: receives a 16-bit word count and then little-endian
// instruction words over a byte stream, and writes them to program memory
// while holding the CPU in reset.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing mod-256
// sum byte over all data bytes before the session completes.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    program_loader_if.master bus,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic             CpuResetHold
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_e AfterData = StChk;
`else
    localparam state_e AfterData = StDone;
`endif

    state_e                  state_q, state_d;
    status_t                 status_q;
    logic [15:0]             n_q;
    logic [15:0]             word_index_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;

    logic                    accept;
    logic                    start_ok;
    logic                    len_done;
    logic                    word_done;
    logic [15:0]             len_value;
    logic                    asm_clear;
    logic                    asm_load;
    logic [8*BYTES_PER_WORD-1:0] asm_word_next;
    logic [1:0]              asm_count;

    assign accept    = bus.ByteValid && status_q.byte_ready;
    assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone) ||
                                 (state_q == StError));
    assign len_done  = (state_q == StLen) && accept && (asm_count == 2'(LEN_BYTES - 1));
    assign word_done = (state_q == StData) && accept &&
                       (asm_count == 2'(BYTES_PER_WORD - 1));
    // Two length bytes shifted in from the top land in the upper half.
    assign len_value = asm_word_next[8*BYTES_PER_WORD-1 -: 16];
    assign asm_load  = accept && ((state_q == StLen) || (state_q == StData));
    assign asm_clear = start_ok || len_done;

    byte_assembler u_byte_assembler (
        .clk_i       (clk),
        .reset_i     (reset),
        .clear_i     (asm_clear),
        .load_i      (asm_load),
        .byte_i      (bus.ByteIn),
        .word_next_o (asm_word_next),
        .count_o     (asm_count)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    // Running mod-256 sum of every accepted data byte.
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            sum_q <= '0;
        end else if ((state_q == StData) && accept) begin
            sum_q <= sum_q + bus.ByteIn;
        end
    end
`endif

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StError: begin
                if (start) state_d = StLen;
            end
            StLen: begin
                if (len_done) begin
                    if (32'(len_value) > MEMORY_DEPTH) state_d = StError;
                    else if (len_value == '0)          state_d = AfterData;
                    else                               state_d = StData;
                end
            end
            StData: begin
                if (word_done) state_d = StWrite;
            end
            StWrite: begin
                state_d = (word_index_q + 16'd1 == n_q) ? AfterData : StData;
            end
            StChk: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) state_d = (bus.ByteIn == sum_q) ? StDone : StError;
`else
                state_d = StDone;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with status outputs registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            status_q <= decode_status(StIdle);
        end else begin
            state_q  <= state_d;
            status_q <= decode_status(state_d);
        end
    end

    // Length, word index and write-port registers; address/data hold outside WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q          <= '0;
            word_index_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            we_q <= (state_d == StWrite);
            if (start_ok) begin
                n_q          <= '0;
                word_index_q <= '0;
            end
            if (len_done) begin
                n_q <= len_value;
            end
            if (word_done) begin
                addr_q <= DATA_WIDTH'(word_index_q) << ADDR_SHIFT;
                data_q <= DATA_WIDTH'(asm_word_next);
            end
            if (state_q == StWrite) begin
                word_index_q <= word_index_q + 16'd1;
            end
        end
    end

    assign bus.ByteReady    = status_q.byte_ready;
    assign bus.WriteEnable  = we_q;
    assign bus.WriteAddress = addr_q;
    assign bus.WriteData    = data_q;
    assign Busy             = status_q.busy;
    assign Done             = status_q.done;
    assign Error            = status_q.error;
    assign CpuResetHold     = status_q.cpu_reset_hold;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a write scoreboard.
module tb_program_loader;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, done, error, cpu_hold;

    always #5 clk = ~clk;

    program_loader_if #(.DATA_WIDTH(32)) bus ();

    program_loader #(
        .MEMORY_DEPTH (32),
        .DATA_WIDTH   (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .Busy         (busy),
        .Done         (done),
        .Error        (error),
        .CpuResetHold (cpu_hold)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          next_index;
    logic [7:0]  sum_model;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.WriteEnable === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 64'(bus.WriteEnable), 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check_eq("write_addr", 64'(bus.WriteAddress), 64'(e.addr));
                check_eq("write_data", 64'(bus.WriteData), 64'(e.data));
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic open_session();
        pulse_start();
        next_index = 0;
        sum_model  = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        bit rdy;
        ok = 1'b0;
        bus.ByteIn    = b;
        bus.ByteValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = bus.ByteReady;
            @(posedge clk); #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.ByteValid = 1'b0;
        check_eq("byte_accept", 64'(ok), 64'd1);
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_len(input logic [15:0] n, input bit gap);
        send_byte(n[7:0], gap);
        send_byte(n[15:8], 1'b0);
    endtask

    task automatic expect_word(input logic [31:0] w);
        wr_t e;
        e.addr = 32'(next_index * 4);
        e.data = w;
        sb.push_back(e);
        next_index++;
        sum_model = sum_model + w[7:0] + w[15:8] + w[23:16] + w[31:24];
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        logic [31:0] v;
        v = w;
        expect_word(w);
        for (int i = 0; i < 4; i++) begin
            send_byte(v[8*i +: 8], gap && (i < 3));
        end
        @(negedge clk);
        check_eq("write_after_4th", 64'(bus.WriteEnable), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic finish_session();
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum_model, 1'b0);
`endif
        @(negedge clk);
        check_eq("done", 64'(done), 64'd1);
        check_eq("cpu_hold_done", 64'(cpu_hold), 64'd0);
        check_eq("busy_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        start         = 1'b1;
        bus.ByteIn    = 8'hA5;
        bus.ByteValid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 64'(bus.ByteReady), 64'd0);
        check_eq("rst_we", 64'(bus.WriteEnable), 64'd0);
        check_eq("rst_addr", 64'(bus.WriteAddress), 64'd0);
        check_eq("rst_data", 64'(bus.WriteData), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        check_eq("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        @(posedge clk); #1;
        reset         = 1'b0;
        start         = 1'b0;
        bus.ByteValid = 1'b0;
        @(posedge clk); #1;

        // Oversized length goes to ERROR and refuses bytes until start.
        open_session();
        @(negedge clk);
        check_eq("len_busy", 64'(busy), 64'd1);
        check_eq("len_ready", 64'(bus.ByteReady), 64'd1);
        @(posedge clk); #1;
        send_len(16'h0021, 1'b0);
        bus.ByteIn    = 8'h13;
        bus.ByteValid = 1'b1;
        @(negedge clk);
        check_eq("err_flag", 64'(error), 64'd1);
        check_eq("err_ready", 64'(bus.ByteReady), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("err_ready_hold", 64'(bus.ByteReady), 64'd0);
        check_eq("err_flag_hold", 64'(error), 64'd1);
        check_eq("err_cpu_hold", 64'(cpu_hold), 64'd1);
        @(posedge clk); #1;
        bus.ByteValid = 1'b0;

        // Two-word program, back-to-back bytes, started from ERROR.
        open_session();
        @(negedge clk);
        check_eq("err_cleared", 64'(error), 64'd0);
        @(posedge clk); #1;
        send_len(16'd2, 1'b0);
        send_word(32'h2000_0013, 1'b0);
        send_word(32'h0800_0008, 1'b0);
        @(negedge clk);
        check_eq("hold_addr", 64'(bus.WriteAddress), 64'h4);
        check_eq("hold_data", 64'(bus.WriteData), 64'h0800_0008);
        @(posedge clk); #1;
        finish_session();

        // Same program with a bubble after every byte, started from DONE.
        open_session();
        send_len(16'd2, 1'b1);
        send_word(32'h2000_0013, 1'b1);
        send_word(32'h0800_0008, 1'b1);
        finish_session();

        // Zero-length session completes without any write.
        open_session();
        send_len(16'd0, 1'b0);
        finish_session();

        // Reset mid-word drops the partial bytes; restart writes word 0 cleanly.
        open_session();
        send_len(16'd1, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        reset         = 1'b1;
        start         = 1'b1;
        bus.ByteIn    = 8'h77;
        bus.ByteValid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_ready", 64'(bus.ByteReady), 64'd0);
        check_eq("midrst_we", 64'(bus.WriteEnable), 64'd0);
        check_eq("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
        @(posedge clk); #1;
        reset         = 1'b0;
        start         = 1'b0;
        bus.ByteValid = 1'b0;
        @(posedge clk); #1;
        open_session();
        send_len(16'd1, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        finish_session();

        // start during DATA is ignored; second word still lands at address 4.
        open_session();
        send_len(16'd2, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        expect_word(32'hCAFE_F00D);
        send_byte(8'h0D, 1'b0);
        send_byte(8'hF0, 1'b0);
        pulse_start();
        @(negedge clk);
        check_eq("start_ignored_busy", 64'(busy), 64'd1);
        check_eq("start_ignored_ready", 64'(bus.ByteReady), 64'd1);
        @(posedge clk); #1;
        send_byte(8'hFE, 1'b0);
        send_byte(8'hCA, 1'b0);
        @(negedge clk);
        check_eq("write_after_4th", 64'(bus.WriteEnable), 64'd1);
        @(posedge clk); #1;
        finish_session();

`ifdef LOADER_CHECKSUM_EN
        // Correct and incorrect check bytes.
        open_session();
        send_len(16'd1, 1'b0);
        send_word(32'h0403_0201, 1'b0);
        check_eq("sum_model", 64'(sum_model), 64'h0A);
        finish_session();
        open_session();
        send_len(16'd1, 1'b0);
        send_word(32'h0403_0201, 1'b0);
        send_byte(8'h0B, 1'b0);
        @(negedge clk);
        check_eq("bad_sum_error", 64'(error), 64'd1);
        check_eq("bad_sum_done", 64'(done), 64'd0);
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
